// File: rtl/reg_status_table.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_status_table: per-register busy/ROB-tag table for dispatch/rename.   |
// | Optional same-cycle commit forwarding: `define REG_STATUS_BYPASS_EN       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module dec5 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);

  // Each output is the AND of the five select literals matching its index.
  for (genvar i = 0; i < 32; i++) begin : g_out
    localparam logic [4:0] C_SEL = 5'(i);
    assign out[i] = en & (&(sel ~^ C_SEL));
  end

endmodule

module reg_status_table #(
  parameter int TAG_W    = 4,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             disp_valid,
  input  logic [4:0]       disp_rd,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic             cmt_valid,
  input  logic [4:0]       cmt_rd,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic             flush,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs2_tag,
  output logic [31:0]      busy_vec
);

  localparam logic [31:0] C_X0_MASK = ~32'h1;

  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic [TAG_W-1:0] tag [NUM_REGS];
  logic [31:0]      disp_oh;
  logic [31:0]      cmt_oh;
  logic [31:0]      disp_we;
  logic [31:0]      cmt_match;
  logic [31:0]      cmt_clr;
  logic             rs1_fwd;
  logic             rs2_fwd;

  dec5 u_dec_disp (.en(disp_valid), .sel(disp_rd), .out(disp_oh));
  dec5 u_dec_cmt  (.en(cmt_valid),  .sel(cmt_rd),  .out(cmt_oh));

  // x0 is never written: masking bit 0 keeps its busy and tag flops at zero.
  assign disp_we = disp_oh & C_X0_MASK;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign cmt_match[i] = (tag[i] == cmt_tag);

    always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
        tag[i] <= '0;
      end else if (disp_we[i] && !flush) begin
        tag[i] <= disp_tag;
      end
    end
  end

  // A commit whose tag no longer matches belongs to a superseded producer.
  assign cmt_clr  = cmt_oh & C_X0_MASK & busy & cmt_match;
  assign busy_nxt = (busy & ~cmt_clr) | disp_we;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_tag = tag[rs1_idx];
  assign rs2_tag = tag[rs2_idx];

`ifdef REG_STATUS_BYPASS_EN
  assign rs1_fwd = cmt_valid & (cmt_rd == rs1_idx) & (rs1_idx != 5'd0) & (rs1_tag == cmt_tag);
  assign rs2_fwd = cmt_valid & (cmt_rd == rs2_idx) & (rs2_idx != 5'd0) & (rs2_tag == cmt_tag);
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif

  assign rs1_busy = busy[rs1_idx] & ~rs1_fwd;
  assign rs2_busy = busy[rs2_idx] & ~rs2_fwd;
  assign busy_vec = busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_status_table.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_status_table: directed vector bench for reg_status_table.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_reg_status_table;

  localparam int TAG_W = 4;
  localparam int NVEC  = 19;

  typedef struct {
    logic             dv;
    logic [4:0]       drd;
    logic [TAG_W-1:0] dtag;
    logic             cv;
    logic [4:0]       crd;
    logic [TAG_W-1:0] ctag;
    logic             fl;
    logic [4:0]       r1;
    logic [4:0]       r2;
    logic             e1b;
    logic [TAG_W-1:0] e1t;
    logic             e2b;
    logic [TAG_W-1:0] e2t;
    logic [31:0]      evec;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_aL;
  logic             disp_valid;
  logic [4:0]       disp_rd;
  logic [TAG_W-1:0] disp_tag;
  logic             cmt_valid;
  logic [4:0]       cmt_rd;
  logic [TAG_W-1:0] cmt_tag;
  logic             flush;
  logic [4:0]       rs1_idx;
  logic [4:0]       rs2_idx;
  logic             rs1_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic             rs2_busy;
  logic [TAG_W-1:0] rs2_tag;
  logic [31:0]      busy_vec;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [NVEC];

  reg_status_table #(.TAG_W(TAG_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag),
    .flush(flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int dv, input int drd, input int dtag,
                              input int cv, input int crd, input int ctag,
                              input int fl, input int r1, input int r2,
                              input int e1b, input int e1t, input int e2b,
                              input int e2t, input logic [31:0] evec);
    vec_t v;
    v.dv = dv[0];    v.drd = drd[4:0];    v.dtag = dtag[TAG_W-1:0];
    v.cv = cv[0];    v.crd = crd[4:0];    v.ctag = ctag[TAG_W-1:0];
    v.fl = fl[0];    v.r1 = r1[4:0];      v.r2 = r2[4:0];
    v.e1b = e1b[0];  v.e1t = e1t[TAG_W-1:0];
    v.e2b = e2b[0];  v.e2t = e2t[TAG_W-1:0];
    v.evec = evec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [4:0] drd, input logic [TAG_W-1:0] dtag,
                       input logic cv, input logic [4:0] crd, input logic [TAG_W-1:0] ctag,
                       input logic fl, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    disp_valid = dv; disp_rd = drd; disp_tag = dtag;
    cmt_valid  = cv; cmt_rd  = crd; cmt_tag  = ctag;
    flush = fl; rs1_idx = r1; rs2_idx = r2;
    #1;
  endtask

  task automatic chk_all(input string tag_s, input logic e1b, input logic [TAG_W-1:0] e1t,
                         input logic e2b, input logic [TAG_W-1:0] e2t, input logic [31:0] evec);
    chk({tag_s, " rs1_busy"}, 32'(rs1_busy), 32'(e1b));
    chk({tag_s, " rs1_tag"},  32'(rs1_tag),  32'(e1t));
    chk({tag_s, " rs2_busy"}, 32'(rs2_busy), 32'(e2b));
    chk({tag_s, " rs2_tag"},  32'(rs2_tag),  32'(e2t));
    chk({tag_s, " busy_vec"}, busy_vec, evec);
  endtask

  task automatic drive_random();
    disp_valid = 1'($urandom); disp_rd = 5'($urandom); disp_tag = TAG_W'($urandom);
    cmt_valid  = 1'($urandom); cmt_rd  = 5'($urandom); cmt_tag  = TAG_W'($urandom);
    flush = 1'($urandom); rs1_idx = 5'($urandom); rs2_idx = 5'($urandom);
  endtask

  initial begin
    //       dv drd dt cv crd ct fl r1 r2 e1b e1t e2b e2t  busy_vec
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  5, 7, 0, 0, 0, 0, 32'h0000_0000);
    tbl[1]  = mk(1, 5, 3, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 32'h0000_0000);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  5, 7, 1, 3, 0, 0, 32'h0000_0020);
    tbl[3]  = mk(0, 0, 0, 1, 5, 3, 0,  7, 0, 0, 0, 0, 0, 32'h0000_0020);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 3, 0, 0, 32'h0000_0000);
    tbl[5]  = mk(1, 7, 1, 0, 0, 0, 0,  5, 0, 0, 3, 0, 0, 32'h0000_0000);
    tbl[6]  = mk(1, 7, 9, 0, 0, 0, 0,  7, 0, 1, 1, 0, 0, 32'h0000_0080);
    tbl[7]  = mk(0, 0, 0, 1, 7, 1, 0,  7, 0, 1, 9, 0, 0, 32'h0000_0080);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  7, 0, 1, 9, 0, 0, 32'h0000_0080);
    tbl[9]  = mk(0, 0, 0, 1, 7, 9, 0,  5, 0, 0, 3, 0, 0, 32'h0000_0080);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  7, 0, 0, 9, 0, 0, 32'h0000_0000);
    tbl[11] = mk(1, 4, 2, 0, 0, 0, 0,  7, 0, 0, 9, 0, 0, 32'h0000_0000);
    tbl[12] = mk(1, 4, 6, 1, 4, 2, 0,  5, 0, 0, 3, 0, 0, 32'h0000_0010);
    tbl[13] = mk(1, 0, 5, 0, 0, 0, 0,  4, 0, 1, 6, 0, 0, 32'h0000_0010);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 4, 0, 0, 1, 6, 32'h0000_0010);
    tbl[15] = mk(0, 0, 0, 1, 5, 3, 0,  4, 7, 1, 6, 0, 9, 32'h0000_0010);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 3, 0, 0, 32'h0000_0010);
    tbl[17] = mk(1,10,11, 1, 4, 6, 0, 10, 7, 0, 0, 0, 9, 32'h0000_0010);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 10, 4, 1,11, 0, 6, 32'h0000_0400);

    // Reset with random inputs toggling: everything reads zero.
    rst_aL = 1'b0;
    drive_random();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_random();
      #1;
      chk($sformatf("reset%0d", c), {rs1_busy, rs2_busy, 2'b00, rs1_tag, rs2_tag, busy_vec[23:0]}, 32'h0);
      chk($sformatf("reset%0d busy_vec_hi", c), {24'h0, busy_vec[31:24]}, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_aL = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].dv, tbl[i].drd, tbl[i].dtag, tbl[i].cv, tbl[i].crd, tbl[i].ctag,
            tbl[i].fl, tbl[i].r1, tbl[i].r2);
      chk_all($sformatf("vec%0d", i), tbl[i].e1b, tbl[i].e1t, tbl[i].e2b, tbl[i].e2t, tbl[i].evec);
    end

    // Fill x1..x31 with tag = rd mod 16, then flush with a dispatch that must be dropped.
    for (int r = 1; r < 32; r++) begin
      drive(1, 5'(r), TAG_W'(r), 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 9, 31);
    chk_all("filled", 1, 9, 1, 15, 32'hFFFF_FFFE);
    drive(1, 9, 2, 0, 0, 0, 1, 9, 31);
    chk_all("flush_cycle", 1, 9, 1, 15, 32'hFFFF_FFFE);
    drive(0, 0, 0, 0, 0, 0, 0, 9, 31);
    chk_all("after_flush", 0, 9, 0, 15, 32'h0000_0000);

    // Same-cycle commit forwarding onto the rs2 lookup.
    drive(1, 12, 4, 0, 0, 0, 0, 0, 12);
    drive(0, 0, 0, 1, 12, 4, 0, 0, 12);
`ifdef REG_STATUS_BYPASS_EN
    chk_all("bypass_cycle", 0, 0, 0, 4, 32'h0000_1000);
`else
    chk_all("bypass_cycle", 0, 0, 1, 4, 32'h0000_1000);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12);
    chk_all("bypass_next", 0, 0, 0, 4, 32'h0000_0000);

    // Asynchronous reset asserted mid-cycle with activity pending.
    drive(1, 3, 5, 0, 0, 0, 0, 3, 12);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 12);
    chk_all("pre_reset", 1, 5, 0, 4, 32'h0000_0008);
    @(negedge clk);
    drive_random();
    rs1_idx = 5'd3;
    rs2_idx = 5'd12;
    #2 rst_aL = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 32'h0000_0000);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 12);
    rst_aL = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 3, 12);
    chk_all("post_reset", 0, 0, 0, 0, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
